// File: rtl/rom_loader_if.sv
// rtl/rom_loader_if.sv - load-stream byte handshake and program-memory write port
interface rom_loader_if #(
  parameter int WORD_SIZE = 20
);
  logic [7:0]           byte_i;
  logic                 byte_valid_i;
  logic                 byte_ready_o;
  logic                 wr_en_o;
  logic [WORD_SIZE-1:0] wr_addr_o;
  logic [WORD_SIZE-1:0] wr_data_o;

  modport master (
    output byte_i, byte_valid_i,
    input  byte_ready_o, wr_en_o, wr_addr_o, wr_data_o
  );

  modport slave (
    input  byte_i, byte_valid_i,
    output byte_ready_o, wr_en_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - byte-stream program loader with word count, checksum and cpu reset hold
module rom_loader #(
  parameter int MEM_SIZE  = 4096,
  parameter int WORD_SIZE = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  rom_loader_if.slave  bus,
  output logic         cpu_reset_o,
  output logic         done_o,
  output logic         error_o
);

  localparam int          HI_W      = WORD_SIZE - 16;
  localparam logic [7:0]  B2_MASK   = 8'((1 << HI_W) - 1);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);
  localparam logic [7:0]  SYNC      = 8'hA5;

  typedef enum logic [3:0] {
    IDLE, CNT_LO, CNT_HI, B0, B1, B2, WRITE, CHECK, DONE, ERROR
  } state_t;

  state_t               state;
  logic [7:0]           checksum;
  logic [7:0]           cnt_lo;
  logic [7:0]           b0;
  logic [7:0]           b1;
  logic [15:0]          remaining;
  logic [WORD_SIZE-1:0] addr;
  logic [WORD_SIZE-1:0] wr_addr;
  logic [WORD_SIZE-1:0] wr_data;
  logic                 wr_en;
  logic                 ready;

  logic                 accept;
  logic [7:0]           sum_next;
  logic [15:0]          count_in;

  assign accept   = bus.byte_valid_i && ready;
  assign sum_next = checksum + bus.byte_i;
  assign count_in = {bus.byte_i, cnt_lo};

  assign bus.byte_ready_o = ready;
  assign bus.wr_en_o      = wr_en;
  assign bus.wr_addr_o    = wr_addr;
  assign bus.wr_data_o    = wr_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      checksum    <= 8'd0;
      cnt_lo      <= 8'd0;
      b0          <= 8'd0;
      b1          <= 8'd0;
      remaining   <= 16'd0;
      addr        <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wr_en       <= 1'b0;
      ready       <= 1'b1;
      cpu_reset_o <= 1'b1;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
    end else begin
      // ready is registered alongside state so it is low exactly in WRITE
      wr_en <= 1'b0;
      ready <= 1'b1;
      case (state)
        IDLE, DONE, ERROR: begin
          if (accept && bus.byte_i == SYNC) begin
            state       <= CNT_LO;
            checksum    <= 8'd0;
            addr        <= '0;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
            cpu_reset_o <= 1'b1;
          end
        end
        CNT_LO: begin
          if (accept) begin
            cnt_lo   <= bus.byte_i;
            checksum <= sum_next;
            state    <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (accept) begin
            checksum  <= sum_next;
            remaining <= count_in;
            if (count_in == 16'd0) begin
              state <= CHECK;
            end else if ({16'd0, count_in} > MEM_LIMIT) begin
              state   <= ERROR;
              error_o <= 1'b1;
            end else begin
              state <= B0;
            end
          end
        end
        B0: begin
          if (accept) begin
            b0       <= bus.byte_i;
            checksum <= sum_next;
            state    <= B1;
          end
        end
        B1: begin
          if (accept) begin
            b1       <= bus.byte_i;
            checksum <= sum_next;
            state    <= B2;
          end
        end
        B2: begin
          if (accept) begin
            checksum <= sum_next;
            if ((bus.byte_i & ~B2_MASK) != 8'd0) begin
              state   <= ERROR;
              error_o <= 1'b1;
            end else begin
              state   <= WRITE;
              wr_en   <= 1'b1;
              ready   <= 1'b0;
              wr_addr <= addr;
              wr_data <= {bus.byte_i[HI_W-1:0], b1, b0};
            end
          end
        end
        WRITE: begin
          addr      <= addr + WORD_SIZE'(1);
          remaining <= remaining - 16'd1;
          state     <= (remaining == 16'd1) ? CHECK : B0;
        end
        CHECK: begin
          if (accept) begin
            checksum <= sum_next;
            if (sum_next == 8'd0) begin
              state       <= DONE;
              done_o      <= 1'b1;
              cpu_reset_o <= 1'b0;
            end else begin
              state   <= ERROR;
              error_o <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 4096, the number of program words the loader may write.
REQ-002 SHALL have parameter WORD_SIZE, default 20, the program word and address width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port byte_i, input, 8 bits: the incoming load-stream byte.
REQ-006 SHALL have port byte_valid_i, input, 1 bit: byte_i is valid this cycle.
REQ-007 SHALL have port byte_ready_o, output, 1 bit: the loader accepts byte_i this cycle.
REQ-008 SHALL have port wr_en_o, output, 1 bit: a program-memory write strobe, one cycle per word.
REQ-009 SHALL have port wr_addr_o, output, WORD_SIZE bits: the program-memory write address.
REQ-010 SHALL have port wr_data_o, output, WORD_SIZE bits: the program-memory write data.
REQ-011 SHALL have port cpu_reset_o, output, 1 bit: holds the processor in reset while a load is pending or in progress.
REQ-012 SHALL have port done_o, output, 1 bit: the last load completed with a good checksum.
REQ-013 SHALL have port error_o, output, 1 bit: the last load failed.

Function
REQ-014 SHALL transfer a byte only on a cycle where byte_valid_i and byte_ready_o are both 1; on all other cycles byte_i SHALL be ignored.
REQ-015 SHALL assert byte_ready_o in every state except WRITE.
REQ-016 SHALL implement these states: IDLE, CNT_LO, CNT_HI, B0, B1, B2, WRITE, CHECK, DONE, ERROR.
REQ-017 IDLE, DONE and ERROR SHALL accept and discard every byte except sync byte 0xA5.
- On 0xA5 the loader SHALL go to CNT_LO, clear the checksum, address, done_o and error_o, and set cpu_reset_o=1.
REQ-018 CNT_LO then CNT_HI SHALL capture a 16-bit little-endian word count N.
- N=0 SHALL go to CHECK.
- N>MEM_SIZE SHALL go to ERROR.
- Otherwise the loader SHALL go to B0.
REQ-019 B0, B1 and B2 SHALL capture each word little-endian, with data = {B2[WORD_SIZE-17:0], B1, B0}.
- If any bit of B2 above bit WORD_SIZE-17 is nonzero, the loader SHALL go to ERROR.
REQ-020 WRITE SHALL last exactly one cycle.
- wr_en_o=1, with wr_addr_o equal to the current address and wr_data_o equal to the assembled word.
- The address SHALL then increment.
- The loader SHALL go to B0 if words remain, else to CHECK.
REQ-021 wr_en_o SHALL be 0 in every state other than WRITE, and the loader SHALL never assert it at an address >= MEM_SIZE.
REQ-022 The checksum SHALL be the 8-bit modulo-256 sum of every accepted byte after the sync byte, including the count bytes and the checksum byte.
- In CHECK, if the sum including the received byte is 0x00, the loader SHALL go to DONE with done_o=1 and cpu_reset_o=0.
- Otherwise it SHALL go to ERROR with error_o=1 and cpu_reset_o held at 1.
REQ-023 The latency from the accepted B2 byte to wr_en_o SHALL be exactly one cycle: the cycle after the acceptance edge.
REQ-024 Words already written before an error SHALL remain in memory; the loader SHALL NOT roll them back.
REQ-025 done_o and error_o SHALL never both be 1, and both SHALL hold until the next sync byte or reset.
REQ-026 wr_addr_o and wr_data_o SHALL be registered and SHALL hold their last values when wr_en_o=0.

Reset
REQ-027 While reset_n=0, the loader SHALL set state=IDLE, wr_en_o=0, wr_addr_o=0, wr_data_o=0, done_o=0, error_o=0, cpu_reset_o=1, byte_ready_o=1 and checksum=0, asynchronously.
REQ-028 Reset asserted mid-load SHALL abort the load with no further writes; after release the loader SHALL wait for a new 0xA5.

Verification
REQ-029 Good load:
- Stimulus: A5, 02 00, 34 12 05, 78 56 0A, checksum = two's complement of the byte sum.
- Response: writes addr0=0x51234 and addr1=0xA5678, then done_o=1 and cpu_reset_o=0.
REQ-030 Bad checksum:
- Stimulus: the same stream with checksum+1.
- Response: both writes occur, then error_o=1, done_o=0 and cpu_reset_o=1.
REQ-031 Oversize and bad high bits:
- Stimulus: count 0x1001.
- Response: ERROR with no writes.
- Stimulus: a B2 byte of 0x15.
- Response: ERROR with no write for that word.
REQ-032 Handshake:
- Stimulus: byte_valid_i toggles randomly, with stalls during WRITE.
- Response: byte_ready_o=0 only in the WRITE cycle, no byte lost or duplicated, and the memory image matches.
REQ-033 Garbage and zero count:
- Stimulus: bytes 00 FF before A5, then count 0000 and checksum 00.
- Response: the leading bytes are ignored, done_o=1, and no writes occur.
REQ-034 Reset and reload:
- Stimulus: reset_n pulsed low after B1 of word 3.
- Response: outputs return to reset values immediately.
- Stimulus: a new full load.
- Response: writes start at addr 0.
